// File: rtl/note_recorder.sv
// note_recorder: records the live note/octave stream as timed events and
// plays it back as a note/octave source. Event lengths are in 1 ms ticks.
//
// Parameters
//   DEPTH_LOG2 : log2 of event store depth
//   LEN_W      : width of the event length field (ms ticks)
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   tick_1ms                : one-cycle pulse per ms
//   rec_start, play_start   : one-cycle commands (accepted in IDLE only)
//   stop                    : one-cycle command, ends recording or playback
//   in_note, in_octave      : live source (note 0 = rest)
//   out_note, out_octave    : playback source, 0/4 when not playing
//   recording, playing      : state flags
//   count                   : number of stored events
//   full                    : last recording ended on a full store
// Build option
//   NOTE_RECORDER_LOOP_EN   : when defined, playback wraps to event 0 until stop
module note_recorder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1ms,
  input  logic                  rec_start,
  input  logic                  play_start,
  input  logic                  stop,
  input  logic [3:0]            in_note,
  input  logic [3:0]            in_octave,
  output logic [3:0]            out_note,
  output logic [3:0]            out_octave,
  output logic                  recording,
  output logic                  playing,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CNT_W  = DEPTH_LOG2 + 1;
  localparam int WORD_W = 8 + LEN_W;
  localparam logic [LEN_W-1:0] LEN_MAX   = '1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REC, PFETCH, PHOLD} state_t;

  state_t                  state, state_next;
  logic [7:0]              cur_key;     // {note, octave} of the event being recorded
  logic [LEN_W-1:0]        cur_len;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [CNT_W-1:0]        rd_ptr;      // one bit wider so it can equal count
  logic [LEN_W-1:0]        remaining;
  logic                    fetch_wait;  // second PFETCH cycle: ram_q holds the word

  logic [WORD_W-1:0]       mem [DEPTH];
  logic [WORD_W-1:0]       ram_q;
  logic                    ram_we, ram_re;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [WORD_W-1:0]       ram_wdata;

  // Recording decode. A tick in the same cycle as a change belongs to the
  // old event, so every decision uses the tick-adjusted length.
  logic [7:0]       in_key;
  logic [LEN_W-1:0] eff_len;
  logic             change, len_nz, saturate, rec_write, last_write;
  logic             hold_expire, play_last;

  assign in_key      = {in_note, in_octave};
  assign eff_len     = cur_len + LEN_W'(tick_1ms);
  assign change      = (in_key != cur_key);
  assign len_nz      = (eff_len != '0);
  assign saturate    = tick_1ms && (eff_len == LEN_MAX);
  assign rec_write   = (state == REC) && (((stop || change) && len_nz) || saturate);
  assign last_write  = rec_write && (count == LAST_SLOT);
  assign hold_expire = (remaining == '0) || (tick_1ms && remaining == LEN_W'(1));
  assign play_last   = ((rd_ptr + CNT_W'(1)) == count);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; command priority is stop > rec_start > play_start.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned
    // (which would infer a latch).
    state_next = state;
    case (state)
      IDLE: begin
        if (!stop && rec_start)                        state_next = REC;
        else if (!stop && play_start && count != '0)   state_next = PFETCH;
      end
      REC: begin
        if (stop || last_write) state_next = IDLE;
      end
      PFETCH: begin
        if (stop)            state_next = IDLE;
        else if (fetch_wait) state_next = PHOLD;
      end
      PHOLD: begin
        if (stop) state_next = IDLE;
        else if (hold_expire) begin
`ifdef NOTE_RECORDER_LOOP_EN
          state_next = PFETCH;
`else
          state_next = play_last ? IDLE : PFETCH;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    recording = (state == REC);
    playing   = (state == PFETCH) || (state == PHOLD);
    ram_we    = rec_write;
    ram_re    = (state == PFETCH) && !fetch_wait;
    ram_addr  = (state == REC) ? wr_ptr : rd_ptr[DEPTH_LOG2-1:0];
    ram_wdata = {cur_key, eff_len};
  end

  // Event store: single port, synchronous write, registered read.
  always_ff @(posedge clk) begin
    // NOTE: the store and its read register are deliberately not reset;
    // count = 0 after reset makes old contents unreachable.
    if (ram_we)      mem[ram_addr] <= ram_wdata;
    else if (ram_re) ram_q         <= mem[ram_addr];
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_note   <= 4'd0;
      out_octave <= 4'd4;
      count      <= '0;
      full       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cur_key    <= '0;
      cur_len    <= '0;
      remaining  <= '0;
      fetch_wait <= 1'b0;
    end else begin
      fetch_wait <= (state == PFETCH) && !fetch_wait && !stop;
      case (state)
        IDLE: begin
          if (!stop && rec_start) begin
            count   <= '0;
            wr_ptr  <= '0;
            full    <= 1'b0;
            cur_key <= in_key;
            cur_len <= '0;
          end else if (!stop && play_start && count != '0) begin
            rd_ptr <= '0;
          end
        end
        REC: begin
          if (rec_write) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            count  <= count + CNT_W'(1);
            if (last_write) full <= 1'b1;
          end
          // A change with zero length just replaces the key: glitch filter.
          if (change) begin
            cur_key <= in_key;
            cur_len <= '0;
          end else if (saturate) begin
            cur_len <= '0;          // continuation event with the same key
          end else begin
            cur_len <= eff_len;
          end
        end
        PFETCH: begin
          if (stop) begin
            out_note   <= 4'd0;
            out_octave <= 4'd4;
          end else if (fetch_wait) begin
            out_note   <= ram_q[WORD_W-1 -: 4];
            out_octave <= ram_q[WORD_W-5 -: 4];
            remaining  <= ram_q[LEN_W-1:0];
          end
        end
        PHOLD: begin
          if (stop) begin
            out_note   <= 4'd0;
            out_octave <= 4'd4;
          end else if (hold_expire) begin
`ifdef NOTE_RECORDER_LOOP_EN
            rd_ptr <= play_last ? '0 : rd_ptr + CNT_W'(1);
`else
            rd_ptr <= rd_ptr + CNT_W'(1);
            if (play_last) begin
              out_note   <= 4'd0;
              out_octave <= 4'd4;
            end
`endif
          end else if (tick_1ms) begin
            remaining <= remaining - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
module tb_note_recorder;

`ifdef NOTE_RECORDER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1ms = 1'b0;
  logic       rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
  logic [3:0] in_note = 4'd0, in_octave = 4'd4;

  // Default-size instance
  logic [3:0] out_note, out_octave;
  logic       recording, playing, full;
  logic [8:0] count;

  // Small instance for store-full and length-saturation cases
  logic [3:0] s_out_note, s_out_octave;
  logic       s_recording, s_playing, s_full;
  logic [2:0] s_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  note_recorder dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms),
    .rec_start(rec_start), .play_start(play_start), .stop(stop),
    .in_note(in_note), .in_octave(in_octave),
    .out_note(out_note), .out_octave(out_octave),
    .recording(recording), .playing(playing), .count(count), .full(full)
  );

  note_recorder #(.DEPTH_LOG2(2), .LEN_W(4)) dut_small (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms),
    .rec_start(rec_start), .play_start(play_start), .stop(stop),
    .in_note(in_note), .in_octave(in_octave),
    .out_note(s_out_note), .out_octave(s_out_octave),
    .recording(s_recording), .playing(s_playing), .count(s_count), .full(s_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // n ms ticks, one every 4 clocks; returns just after the edge of the last tick.
  task automatic run_ticks(input int n);
    repeat (n) begin
      repeat (3) cyc();
      tick_1ms = 1'b1;
      cyc();
      tick_1ms = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_rec();
    rec_start = 1'b1; cyc(); rec_start = 1'b0;
  endtask

  task automatic pulse_play();
    play_start = 1'b1; cyc(); play_start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  initial begin
    // ---------------- reset state
    cyc();
    do_reset();
    check("rst_note", out_note, 4'd0);
    check("rst_oct", out_octave, 4'd4);
    check("rst_count", count, 9'd0);
    check("rst_full", full, 1'b0);
    check("rst_flags", {recording, playing}, 2'b00);

    // ---------------- record 1/4 x300, 3/5 x200, then play
    in_note = 4'd1; in_octave = 4'd4;
    pulse_rec();
    check("rec_flag", recording, 1'b1);
    run_ticks(300);
    in_note = 4'd3; in_octave = 4'd5;
    run_ticks(200);
    pulse_stop();
    check("rp_count", count, 9'd2);
    check("rp_rec_off", recording, 1'b0);

    pulse_play();
    check("rp_playing", playing, 1'b1);
    cyc();
    check("rp_lat1", out_note, 4'd0);
    cyc();
    check("rp_note0", {out_note, out_octave}, 8'h14);
    run_ticks(299);
    check("rp_hold0", {out_note, out_octave}, 8'h14);
    run_ticks(1);
    cyc();
    check("rp_gap", {out_note, out_octave}, 8'h14);
    cyc();
    check("rp_note1", {out_note, out_octave}, 8'h35);
    run_ticks(199);
    check("rp_hold1", {out_note, out_octave}, 8'h35);
    run_ticks(1);
    check("rp_end_note", out_note, LOOP ? 4'd3 : 4'd0);
    check("rp_end_play", playing, LOOP);
    cyc(); cyc();
    check("rp_wrap_note", {out_note, out_octave}, LOOP ? 8'h14 : 8'h04);

    // ---------------- glitch filter
    do_reset();
    in_note = 4'd2; in_octave = 4'd4;
    pulse_rec();
    run_ticks(3);
    in_note = 4'd5; cyc();
    check("gl_first", count, 9'd1);
    in_note = 4'd6; cyc();
    check("gl_filtered", count, 9'd1);
    run_ticks(4);
    in_note = 4'd7; cyc();
    check("gl_next", count, 9'd2);
    pulse_stop();
    check("gl_stop", count, 9'd2);
    pulse_play(); cyc(); cyc();
    check("gl_play0", out_note, 4'd2);
    run_ticks(3);
    cyc(); cyc();
    check("gl_play1", out_note, 4'd6);

    // ---------------- full store (small instance, depth 4)
    do_reset();
    in_note = 4'd1; in_octave = 4'd4;
    pulse_rec();
    for (int i = 1; i <= 4; i++) begin
      run_ticks(10);
      in_note = 4'(i + 1);
      cyc();
      if (i == 3) begin
        check("full_cnt3", s_count, 3'd3);
        check("full_rec3", s_recording, 1'b1);
      end
    end
    check("full_count", s_count, 3'd4);
    check("full_flag", s_full, 1'b1);
    check("full_rec_off", s_recording, 1'b0);

    // ---------------- length saturation (small instance, 4-bit length)
    do_reset();
    in_note = 4'd9; in_octave = 4'd3;
    pulse_rec();
    run_ticks(15);
    check("sat_cnt1", s_count, 3'd1);
    run_ticks(5);
    pulse_stop();
    check("sat_cnt2", s_count, 3'd2);
    check("sat_full", s_full, 1'b0);
    pulse_play(); cyc(); cyc();
    check("sat_play0", {s_out_note, s_out_octave}, 8'h93);
    run_ticks(15);
    cyc();
    check("sat_seam_a", s_out_note, 4'd9);
    cyc();
    check("sat_seam_b", s_out_note, 4'd9);
    run_ticks(4);
    check("sat_tail", s_out_note, 4'd9);
    run_ticks(1);
    check("sat_end", s_out_note, LOOP ? 4'd9 : 4'd0);
    check("sat_end_play", s_playing, LOOP);

    // ---------------- stop + rec_start during PHOLD
    do_reset();
    in_note = 4'd1; in_octave = 4'd4;
    pulse_rec();
    run_ticks(5);
    pulse_stop();
    check("cf_count", count, 9'd1);
    pulse_play(); cyc(); cyc();
    run_ticks(2);
    check("cf_hold", {out_note, playing}, 5'b0001_1);
    stop = 1'b1; rec_start = 1'b1;
    cyc();
    stop = 1'b0; rec_start = 1'b0;
    check("cf_out", {out_note, out_octave}, 8'h04);
    check("cf_flags", {recording, playing}, 2'b00);
    cyc();
    check("cf_no_rec", recording, 1'b0);
    check("cf_count_kept", count, 9'd1);

    // ---------------- reset mid-PHOLD
    pulse_play(); cyc(); cyc();
    run_ticks(1);
    check("rm_before", out_note, 4'd1);
    do_reset();
    check("rm_out", {out_note, out_octave}, 8'h04);
    check("rm_count", count, 9'd0);
    check("rm_flags", {recording, playing, full}, 3'b000);

    // ---------------- play_start with empty store
    pulse_play();
    check("empty_play", playing, 1'b0);
    cyc();
    check("empty_idle", {playing, out_note}, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
